// File: rtl/result_reader_if.sv
// Bus bundle for result_reader: sigmoid-memory read port, start pulse and result handshake.
// Optional RESULT_TIE_FLAG_EN adds the result_tie signal.
interface result_reader_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 4
);
  logic              network_done;
  logic              sig_rd_en;
  logic [ADDR_W-1:0] sig_rd_addr;
  logic [DATA_W-1:0] sig_rd_data;
  logic              busy;
  logic              result_valid;
  logic [3:0]        result_digit;
  logic [DATA_W-1:0] result_value;
  logic              result_ack;
`ifdef RESULT_TIE_FLAG_EN
  logic              result_tie;
`endif

  modport master (
    input  network_done, sig_rd_data, result_ack,
`ifdef RESULT_TIE_FLAG_EN
    output result_tie,
`endif
    output sig_rd_en, sig_rd_addr, busy, result_valid, result_digit, result_value
  );

  modport slave (
    output network_done, sig_rd_data, result_ack,
`ifdef RESULT_TIE_FLAG_EN
    input  result_tie,
`endif
    input  sig_rd_en, sig_rd_addr, busy, result_valid, result_digit, result_value
  );
endinterface

// File: rtl/result_reader.sv
// Scans the layer-2 sigmoid outputs after network_done and reports the argmax digit under valid/ack.
// Optional RESULT_TIE_FLAG_EN adds result_tie (a later index matched the running max).
module result_reader #(
  parameter int unsigned NUM_OUTPUTS = 10,
  parameter int unsigned BASE_ADDR   = 8,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned DATA_W      = 4
) (
  input  logic           clk,
  input  logic           n_rst,
  result_reader_if.master bus
);

  localparam int unsigned CNT_W = $clog2(NUM_OUTPUTS + 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_max;
  logic [3:0]        r_idx;
  logic              r_rd_en;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_busy;
  logic              r_valid;
  logic [3:0]        r_digit;
  logic [DATA_W-1:0] r_value;

  logic              w_active;
  logic              w_gt;
  logic [3:0]        w_cmp_idx;
  logic [DATA_W-1:0] w_nxt_max;
  logic [3:0]        w_nxt_idx;

`ifdef RESULT_TIE_FLAG_EN
  logic r_tie_run;
  logic r_tie;
  logic w_nxt_tie;
`endif

  // r_count is the index being addressed this cycle, so returning data belongs to r_count-1
  always_comb begin
    w_active  = ((r_state == READ) && (r_count != '0)) || (r_state == DRAIN);
    w_cmp_idx = 4'(r_count - CNT_W'(1));
    w_gt      = bus.sig_rd_data > r_max;
    w_nxt_max = r_max;
    w_nxt_idx = r_idx;
    if (w_active && w_gt) begin
      w_nxt_max = bus.sig_rd_data;
      w_nxt_idx = w_cmp_idx;
    end
`ifdef RESULT_TIE_FLAG_EN
    w_nxt_tie = r_tie_run;
    if (w_active) begin
      if (w_gt)
        w_nxt_tie = 1'b0;
      else if (bus.sig_rd_data == r_max)
        w_nxt_tie = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_max     <= '0;
      r_idx     <= '0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_digit   <= '0;
      r_value   <= '0;
`ifdef RESULT_TIE_FLAG_EN
      r_tie_run <= 1'b0;
      r_tie     <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_count <= '0;
          r_max   <= '0;
          r_idx   <= '0;
`ifdef RESULT_TIE_FLAG_EN
          r_tie_run <= 1'b0;
`endif
          if (bus.network_done) begin
            r_state   <= READ;
            r_rd_en   <= 1'b1;
            r_rd_addr <= ADDR_W'(BASE_ADDR);
            r_busy    <= 1'b1;
          end
        end
        READ: begin
          r_max   <= w_nxt_max;
          r_idx   <= w_nxt_idx;
          r_count <= r_count + 1'b1;
`ifdef RESULT_TIE_FLAG_EN
          r_tie_run <= w_nxt_tie;
`endif
          if (r_count == CNT_W'(NUM_OUTPUTS - 1)) begin
            r_state   <= DRAIN;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
          end else begin
            r_rd_addr <= ADDR_W'(BASE_ADDR + r_count + 1);
          end
        end
        DRAIN: begin
          r_state <= DONE;
          r_busy  <= 1'b0;
          r_valid <= 1'b1;
          r_max   <= w_nxt_max;
          r_idx   <= w_nxt_idx;
          r_digit <= w_nxt_idx;
          r_value <= w_nxt_max;
`ifdef RESULT_TIE_FLAG_EN
          r_tie_run <= w_nxt_tie;
          r_tie     <= w_nxt_tie;
`endif
        end
        DONE: begin
          // restart wins over a simultaneous ack
          if (bus.network_done) begin
            r_state   <= READ;
            r_count   <= '0;
            r_max     <= '0;
            r_idx     <= '0;
            r_rd_en   <= 1'b1;
            r_rd_addr <= ADDR_W'(BASE_ADDR);
            r_busy    <= 1'b1;
            r_valid   <= 1'b0;
            r_digit   <= '0;
            r_value   <= '0;
`ifdef RESULT_TIE_FLAG_EN
            r_tie_run <= 1'b0;
            r_tie     <= 1'b0;
`endif
          end else if (bus.result_ack) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_digit <= '0;
            r_value <= '0;
`ifdef RESULT_TIE_FLAG_EN
            r_tie   <= 1'b0;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.sig_rd_en    = r_rd_en;
  assign bus.sig_rd_addr  = r_rd_addr;
  assign bus.busy         = r_busy;
  assign bus.result_valid = r_valid;
  assign bus.result_digit = r_digit;
  assign bus.result_value = r_value;
`ifdef RESULT_TIE_FLAG_EN
  assign bus.result_tie   = r_tie;
`endif

endmodule

// File: tb/tb_result_reader.sv
// Scoreboard bench for result_reader: directed scans with a 1-cycle-latency sigmoid memory model.
module tb_result_reader;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  result_reader_if #(.ADDR_W(5), .DATA_W(4)) bus ();

  result_reader #(
    .NUM_OUTPUTS(10),
    .BASE_ADDR  (8),
    .ADDR_W     (5),
    .DATA_W     (4)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  typedef struct {
    int digit;
    int value;
    int tie;
  } exp_t;

  exp_t sb_q[$];
  int   addr_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   t_e0 = 0;

  logic [3:0] mem [32];

  function automatic void check(string name, int act, int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    if (bus.sig_rd_en) bus.sig_rd_data <= mem[bus.sig_rd_addr];

  // monitor: address order, idle address, busy length and result scoreboard
  logic prev_valid = 1'b0;
  logic prev_busy  = 1'b0;
  int   busy_cnt   = 0;
  always @(negedge clk) begin
    if (!n_rst) begin
      prev_valid = 1'b0;
      prev_busy  = 1'b0;
      busy_cnt   = 0;
    end else begin
      if (bus.sig_rd_en) begin
        if (addr_q.size() == 0) check("unexpected_read", 1, 0);
        else check("rd_addr", int'(bus.sig_rd_addr), addr_q.pop_front());
      end else begin
        check("idle_addr", int'(bus.sig_rd_addr), 0);
      end
      if (bus.busy) busy_cnt++;
      else if (prev_busy) begin
        check("busy_len", busy_cnt, 11);
        busy_cnt = 0;
      end
      if (bus.result_valid && !prev_valid) begin
        if (sb_q.size() == 0) check("extra_result", 1, 0);
        else begin
          exp_t e;
          e = sb_q.pop_front();
          check("digit", int'(bus.result_digit), e.digit);
          check("value", int'(bus.result_value), e.value);
          check("valid_cycle", cyc - t_e0 + 1, 12);
`ifdef RESULT_TIE_FLAG_EN
          check("tie", int'(bus.result_tie), e.tie);
`endif
        end
      end
      prev_valid = bus.result_valid;
      prev_busy  = bus.busy;
    end
  end

  task automatic load(input logic [39:0] v);
    for (int i = 0; i < 32; i++) mem[i] = 4'hF;
    for (int i = 0; i < 10; i++) mem[8 + i] = v[39 - 4*i -: 4];
  endtask

  task automatic expect_scan(input int d, input int val, input int tie);
    exp_t e;
    e.digit = d; e.value = val; e.tie = tie;
    sb_q.push_back(e);
    for (int i = 8; i <= 17; i++) addr_q.push_back(i);
  endtask

  task automatic start();
    @(posedge clk) #1 bus.network_done = 1'b1;
    @(posedge clk) #1 bus.network_done = 1'b0;
    t_e0 = cyc;
  endtask

  task automatic wait_valid();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.result_valid) return;
    end
    check("valid_timeout", 0, 1);
  endtask

  task automatic do_ack();
    @(posedge clk) #1 bus.result_ack = 1'b1;
    @(posedge clk) #1 bus.result_ack = 1'b0;
    @(negedge clk);
    check("valid_after_ack", int'(bus.result_valid), 0);
  endtask

  task automatic run(input logic [39:0] v, input int d, input int val, input int tie);
    load(v);
    expect_scan(d, val, tie);
    start();
    wait_valid();
    do_ack();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.network_done = 1'b0;
    bus.result_ack   = 1'b0;
    load('0);
    #12;
    check("rst_valid", int'(bus.result_valid), 0);
    check("rst_busy",  int'(bus.busy), 0);
    check("rst_rd_en", int'(bus.sig_rd_en), 0);
    check("rst_digit", int'(bus.result_digit), 0);
`ifdef RESULT_TIE_FLAG_EN
    check("rst_tie",   int'(bus.result_tie), 0);
`endif
    @(posedge clk) #1 n_rst = 1'b1;

    run({4'd1,4'd2,4'd3,4'd4,4'd15,4'd5,4'd6,4'd7,4'd8,4'd9}, 4, 15, 0);
    run(40'h0, 0, 0, 1);
    run({4'd3,4'd9,4'd2,4'd9,4'd0,4'd0,4'd0,4'd0,4'd0,4'd1}, 1, 9, 1);
    run({4'd3,4'd9,4'd2,4'd9,4'd0,4'd0,4'd0,4'd0,4'd0,4'd12}, 9, 12, 0);

    // network_done re-pulsed mid-scan must not disturb the scan
    load({4'd0,4'd0,4'd7,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0});
    expect_scan(2, 7, 0);
    start();
    repeat (4) @(posedge clk);
    #1 bus.network_done = 1'b1;
    @(posedge clk) #1 bus.network_done = 1'b0;
    wait_valid();

    // restart from DONE with simultaneous ack
    load({4'd5,4'd5,4'd5,4'd5,4'd5,4'd5,4'd5,4'd5,4'd5,4'd6});
    expect_scan(9, 6, 0);
    @(posedge clk) #1 begin bus.network_done = 1'b1; bus.result_ack = 1'b1; end
    @(posedge clk) #1 begin bus.network_done = 1'b0; bus.result_ack = 1'b0; end
    t_e0 = cyc;
    @(negedge clk);
    check("restart_valid", int'(bus.result_valid), 0);
    check("restart_busy",  int'(bus.busy), 1);
    wait_valid();
    do_ack();

    // reset during READ cycle 4
    load({4'd9,4'd9,4'd9,4'd9,4'd9,4'd9,4'd9,4'd9,4'd9,4'd9});
    for (int i = 8; i <= 17; i++) addr_q.push_back(i);
    start();
    repeat (3) @(posedge clk);
    #2 n_rst = 1'b0;
    #1;
    check("midrst_busy",  int'(bus.busy), 0);
    check("midrst_rd_en", int'(bus.sig_rd_en), 0);
    check("midrst_addr",  int'(bus.sig_rd_addr), 0);
    check("midrst_valid", int'(bus.result_valid), 0);
    check("midrst_value", int'(bus.result_value), 0);
    addr_q.delete();
    @(posedge clk) #1 n_rst = 1'b1;
    run({4'd2,4'd1,4'd0,4'd14,4'd14,4'd3,4'd0,4'd0,4'd0,4'd13}, 3, 14, 1);

    repeat (3) @(negedge clk);
    check("sb_leftover",   sb_q.size(), 0);
    check("addr_leftover", addr_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/result_reader.md
# result_reader

Post-inference result reader for the digit recognizer. After the network controller pulses `network_done`, this block reads the ten layer-2 sigmoid outputs from sigmoid memory (addresses 8-17). It selects the index of the largest activation as the recognized digit and holds the result under a valid/ack handshake until the host consumes it. It is the read-side consumer of the sigmoid memory that the network controller writes.

## Interface
Parameters:
- NUM_OUTPUTS, 10, number of output neurons scanned
- BASE_ADDR, 8, sigmoid address of output neuron 0
- ADDR_W, 5, sigmoid address width
- DATA_W, 4, sigmoid data width

Ports:
- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- network_done  in  1  single-cycle pulse from network controller: layer 2 complete
- sig_rd_en  out  1  read request to sigmoid memory
- sig_rd_addr  out  ADDR_W  read address
- sig_rd_data  in  DATA_W  read data, valid one cycle after the address/enable cycle
- busy  out  1  high while scanning (READ, DRAIN)
- result_valid  out  1  digit/value held valid
- result_digit  out  4  argmax index, 0..NUM_OUTPUTS-1
- result_value  out  DATA_W  activation of the winning neuron
- result_ack  in  1  host consumed result

## Operation
- FSM states: IDLE, READ, DRAIN, DONE.
- Reset values: all outputs 0; state IDLE; index counter 0; running max 0.
- IDLE:
  - `network_done`=1 -> READ.
  - Clear the running max to 0, the running index to 0, and the counter to 0.
- READ:
  - Drive sig_rd_en=1 and sig_rd_addr=BASE_ADDR+count.
  - Increment count each cycle.
  - When count==NUM_OUTPUTS-1 -> DRAIN.
- Compare step, active in READ (except its first cycle) and in DRAIN:
  - sig_rd_data holds the value for index count-1 (DRAIN: index NUM_OUTPUTS-1).
  - If data > running max (unsigned, strict), load max=data and index=that index.
- Tie rule: the strict comparison means the lowest index wins a tie. All-zero data gives digit 0, value 0.
- DRAIN: sig_rd_en=0, perform the final compare, -> DONE.
- DONE:
  - result_valid=1; result_digit and result_value are registered and stable.
  - result_ack=1 -> IDLE with result_valid cleared.
- `network_done` while busy (READ/DRAIN) is ignored; the scan completes unchanged.
- `network_done` in DONE restarts the scan: result_valid drops, state goes to READ, and the registers are cleared. This takes priority over a simultaneous result_ack.
- result_ack outside DONE has no effect.
- Reset mid-scan returns to IDLE with all outputs 0 and no residual result.
- sig_rd_addr is 0 whenever sig_rd_en=0.

## Timing
- Edge E0 samples network_done=1.
- Cycles 1..NUM_OUTPUTS are READ, with sig_rd_addr = 8..17.
- Cycle NUM_OUTPUTS+1 is DRAIN.
- result_valid rises at cycle NUM_OUTPUTS+2, which is 12 cycles after E0 at default parameters.
- busy is high for exactly NUM_OUTPUTS+1 cycles.
- Read latency is fixed at 1 cycle. No backpressure is taken from memory.
- result_valid falls on the cycle after the edge that samples result_ack=1 in DONE.
- Minimum restart: one IDLE cycle after ack, or zero cycles via network_done in DONE.

## Configuration
- RESULT_TIE_FLAG_EN defined:
  - Adds output result_tie (1 bit, reset 0).
  - result_tie is set when any later index returns data equal to the running max at the time of compare.
  - result_tie is cleared when a strictly larger value is later loaded.
  - It is valid alongside result_valid and is cleared on restart and reset.
- RESULT_TIE_FLAG_EN undefined: no result_tie port and no tie-tracking logic. Digit selection is identical in both builds.

## Test plan
- Outputs [1,2,3,4,15,5,6,7,8,9], network_done pulse -> result_valid 12 cycles later, digit=4, value=15, addresses 8..17 observed in order.
- All outputs 0 -> digit=0, value=0; result_tie=1 with RESULT_TIE_FLAG_EN.
- Outputs [3,9,2,9,0,0,0,0,0,1] -> digit=1, value=9; result_tie=1 with RESULT_TIE_FLAG_EN.
- Outputs [3,9,2,9,0,0,0,0,0,12] -> digit=9, value=12; result_tie=0 with RESULT_TIE_FLAG_EN.
- network_done re-pulsed at READ cycle 5 -> ignored, single result at cycle 12. Then network_done together with result_ack in DONE -> valid drops and a new scan starts with busy=1.
- n_rst asserted at READ cycle 4 -> all outputs 0 immediately. Release, then pulse network_done -> normal full scan and correct result.
